// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the view of whatever drives the requests.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   i_pc_addr;
  logic            i_pc_rd;
  logic [DW-1:0]   o_pc_rddata;
  logic            o_pc_waitreq;
  logic            o_pc_rdvalid;

  logic [AW-1:0]   i_ldst_addr;
  logic            i_ldst_rd;
  logic            i_ldst_wr;
  logic [DW-1:0]   i_ldst_wrdata;
  logic [DW/8-1:0] i_ldst_byte_en;
  logic [DW-1:0]   o_ldst_rddata;
  logic            o_ldst_waitreq;
  logic            o_ldst_rdvalid;

  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_rd;
  logic            o_mem_wr;
  logic [DW-1:0]   o_mem_wrdata;
  logic [DW/8-1:0] o_mem_byte_en;
  logic [DW-1:0]   i_mem_rddata;

  modport slave (
    input  i_pc_addr, i_pc_rd,
    output o_pc_rddata, o_pc_waitreq, o_pc_rdvalid,
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
    output o_ldst_rddata, o_ldst_waitreq, o_ldst_rdvalid,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata, o_mem_byte_en,
    input  i_mem_rddata
  );

  modport master (
    output i_pc_addr, i_pc_rd,
    input  o_pc_rddata, o_pc_waitreq, o_pc_rdvalid,
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
    input  o_ldst_rddata, o_ldst_waitreq, o_ldst_rdvalid,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata, o_mem_byte_en,
    output i_mem_rddata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency memory.
// Grants are combinational with alternating priority; a small FSM tracks which requester owns the returning read.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int BEW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PC_RD = 2'd1,
    LS_RD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_last_grant;

  logic            w_pc_req;
  logic            w_ls_req;
  logic            w_grant_pc;
  logic            w_grant_ls;
  logic            w_ls_is_rd;

  logic [AW-1:0]   w_mem_addr;
  logic            w_mem_rd;
  logic            w_mem_wr;
  logic [DW-1:0]   w_mem_wrdata;
  logic [BEW-1:0]  w_mem_byte_en;

  assign w_pc_req   = bus.i_pc_rd;
  assign w_ls_req   = bus.i_ldst_rd | bus.i_ldst_wr;
  assign w_ls_is_rd = bus.i_ldst_rd;

  // Under contention the requester not served last wins (r_last_grant: 0 = pc, 1 = ldst)
  assign w_grant_pc = w_pc_req & (~w_ls_req | r_last_grant);
  assign w_grant_ls = w_ls_req & (~w_pc_req | ~r_last_grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_grant_pc) begin
        r_last_grant <= 1'b0;
      end else if (w_grant_ls) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  // Next state only records who issued a read this cycle, so it does not depend on r_state
  always_comb begin
    w_next_state  = IDLE;
    w_mem_addr    = '0;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_mem_wrdata  = '0;
    w_mem_byte_en = '0;
    if (w_grant_pc) begin
      w_next_state  = PC_RD;
      w_mem_addr    = bus.i_pc_addr;
      w_mem_rd      = 1'b1;
      w_mem_byte_en = {BEW{1'b1}};
    end else if (w_grant_ls) begin
      w_mem_addr    = bus.i_ldst_addr;
      w_mem_byte_en = bus.i_ldst_byte_en;
      w_mem_wrdata  = bus.i_ldst_wrdata;
      if (w_ls_is_rd) begin
        w_next_state = LS_RD;
        w_mem_rd     = 1'b1;
      end else begin
        w_mem_wr     = 1'b1;
      end
    end
  end

  assign bus.o_pc_waitreq   = w_pc_req & ~w_grant_pc;
  assign bus.o_ldst_waitreq = w_ls_req & ~w_grant_ls;

  assign bus.o_mem_addr     = w_mem_addr;
  assign bus.o_mem_rd       = w_mem_rd;
  assign bus.o_mem_wr       = w_mem_wr;
  assign bus.o_mem_wrdata   = w_mem_wrdata;
  assign bus.o_mem_byte_en  = w_mem_byte_en;

  assign bus.o_pc_rdvalid   = (r_state == PC_RD);
  assign bus.o_ldst_rdvalid = (r_state == LS_RD);
  assign bus.o_pc_rddata    = bus.i_mem_rddata;
  assign bus.o_ldst_rddata  = bus.i_mem_rddata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus sequences for
// contention fairness and asynchronous reset during an outstanding read.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcRd;
    logic [31:0] pcAddr;
    logic        lsRd;
    logic        lsWr;
    logic [31:0] lsAddr;
    logic [31:0] lsWrdata;
    logic [3:0]  lsBe;
    logic [31:0] memRddata;
    logic        ePcWait;
    logic        eLsWait;
    logic        eMemRd;
    logic        eMemWr;
    logic [31:0] eAddr;
    logic [31:0] eWrdata;
    logic [3:0]  eBe;
    logic        ePcValid;
    logic        eLsValid;
  } vec_t;

  vec_t vecs [10];

  task automatic applyStimulus(input logic pcRd, input logic [31:0] pcAddr,
                               input logic lsRd, input logic lsWr, input logic [31:0] lsAddr,
                               input logic [31:0] lsWrdata, input logic [3:0] lsBe,
                               input logic [31:0] memRddata);
    bus.i_pc_rd          = pcRd;
    bus.i_pc_addr        = pcAddr;
    bus.i_ldst_rd        = lsRd;
    bus.i_ldst_wr        = lsWr;
    bus.i_ldst_addr      = lsAddr;
    bus.i_ldst_wrdata    = lsWrdata;
    bus.i_ldst_byte_en   = lsBe;
    bus.i_mem_rddata     = memRddata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int  pcCount;
    int  lsCount;
    logic expPc;

    nChecks = 0;
    nFails  = 0;
    reset   = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

    //            pcRd  pcAddr     lsRd  lsWr  lsAddr     lsWrdata       lsBe  memRddata       ePcW  eLsW  eRd   eWr   eAddr      eWrdata        eBe   ePcV  eLsV
    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h20, 32'h000000AB, 4'h1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h000000AB, 4'h1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h55,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hFFFF,     4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0,        4'hF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h50, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'hCAFE0001,  1'b0, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0,        4'hF, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h60, 1'b1, 1'b0, 32'h70, 32'h0,        4'hF, 32'hBEEF0002,  1'b1, 1'b0, 1'b1, 1'b0, 32'h70, 32'h0,        4'hF, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h60, 1'b0, 1'b1, 32'h80, 32'h12345678, 4'hC, 32'h0BAD0003,  1'b0, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0,        4'hF, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 32'h12345678, 4'hC, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h12345678, 4'hC, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0, 1'b0, 1'b0};

    // Reset state, observed while reset is held low
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_pc_rdvalid", {31'h0, bus.o_pc_rdvalid}, 32'h0);
    checkOutput("rst_ls_rdvalid", {31'h0, bus.o_ldst_rdvalid}, 32'h0);
    checkOutput("rst_mem_rd", {31'h0, bus.o_mem_rd}, 32'h0);
    checkOutput("rst_mem_wr", {31'h0, bus.o_mem_wr}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].pcRd, vecs[i].pcAddr, vecs[i].lsRd, vecs[i].lsWr, vecs[i].lsAddr,
                    vecs[i].lsWrdata, vecs[i].lsBe, vecs[i].memRddata);
      #1;
      checkOutput($sformatf("v%0d_pc_waitreq", i), {31'h0, bus.o_pc_waitreq}, {31'h0, vecs[i].ePcWait});
      checkOutput($sformatf("v%0d_ls_waitreq", i), {31'h0, bus.o_ldst_waitreq}, {31'h0, vecs[i].eLsWait});
      checkOutput($sformatf("v%0d_mem_rd", i), {31'h0, bus.o_mem_rd}, {31'h0, vecs[i].eMemRd});
      checkOutput($sformatf("v%0d_mem_wr", i), {31'h0, bus.o_mem_wr}, {31'h0, vecs[i].eMemWr});
      checkOutput($sformatf("v%0d_pc_rdvalid", i), {31'h0, bus.o_pc_rdvalid}, {31'h0, vecs[i].ePcValid});
      checkOutput($sformatf("v%0d_ls_rdvalid", i), {31'h0, bus.o_ldst_rdvalid}, {31'h0, vecs[i].eLsValid});
      checkOutput($sformatf("v%0d_pc_rddata", i), bus.o_pc_rddata, vecs[i].memRddata);
      checkOutput($sformatf("v%0d_ls_rddata", i), bus.o_ldst_rddata, vecs[i].memRddata);
      if (vecs[i].eMemRd || vecs[i].eMemWr) begin
        checkOutput($sformatf("v%0d_mem_addr", i), bus.o_mem_addr, vecs[i].eAddr);
        checkOutput($sformatf("v%0d_mem_byte_en", i), {28'h0, bus.o_mem_byte_en}, {28'h0, vecs[i].eBe});
      end
      if (vecs[i].eMemWr) begin
        checkOutput($sformatf("v%0d_mem_wrdata", i), bus.o_mem_wrdata, vecs[i].eWrdata);
      end
    end

    // Continuous contention from reset: pc first, then strict alternation
    doReset();
    pcCount = 0;
    lsCount = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) begin
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0);
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      end
      #1;
      if (i < 8) begin
        expPc = ((i % 2) == 0);
        checkOutput($sformatf("cont%0d_pc_waitreq", i), {31'h0, bus.o_pc_waitreq}, {31'h0, ~expPc});
        checkOutput($sformatf("cont%0d_ls_waitreq", i), {31'h0, bus.o_ldst_waitreq}, {31'h0, expPc});
        checkOutput($sformatf("cont%0d_mem_addr", i), bus.o_mem_addr, expPc ? 32'h0 : 32'h100);
      end
      checkOutput($sformatf("cont%0d_pc_rdvalid", i), {31'h0, bus.o_pc_rdvalid},
                  (i > 0 && ((i - 1) % 2) == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("cont%0d_ls_rdvalid", i), {31'h0, bus.o_ldst_rdvalid},
                  (i > 0 && ((i - 1) % 2) == 1) ? 32'h1 : 32'h0);
      checkOutput($sformatf("cont%0d_both_rdvalid", i), {31'h0, bus.o_pc_rdvalid & bus.o_ldst_rdvalid}, 32'h0);
      pcCount += int'(bus.o_pc_rdvalid);
      lsCount += int'(bus.o_ldst_rdvalid);
    end
    checkOutput("cont_pc_rdvalid_count", pcCount, 32'd4);
    checkOutput("cont_ls_rdvalid_count", lsCount, 32'd4);

    // Asynchronous reset while a pc read is outstanding
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("arst_grant_mem_rd", {31'h0, bus.o_mem_rd}, 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("arst_pc_rdvalid_before", {31'h0, bus.o_pc_rdvalid}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("arst_pc_rdvalid_dropped", {31'h0, bus.o_pc_rdvalid}, 32'h0);
    checkOutput("arst_ls_rdvalid_dropped", {31'h0, bus.o_ldst_rdvalid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("arst_post%0d_pc_rdvalid", i), {31'h0, bus.o_pc_rdvalid}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; byte-enable width is DW/8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; 0 resets immediately, regardless of clk.
REQ-005 SHALL have ports i_pc_addr (in, AW), i_pc_rd (in, 1), o_pc_rddata (out, DW), o_pc_waitreq (out, 1), o_pc_rdvalid (out, 1), meaning the instruction-fetch requester, read-only.
REQ-006 SHALL have ports i_ldst_addr (in, AW), i_ldst_rd (in, 1), i_ldst_wr (in, 1), i_ldst_wrdata (in, DW), i_ldst_byte_en (in, DW/8), o_ldst_rddata (out, DW), o_ldst_waitreq (out, 1), o_ldst_rdvalid (out, 1), meaning the load/store requester.
REQ-007 SHALL have ports o_mem_addr (out, AW), o_mem_rd (out, 1), o_mem_wr (out, 1), o_mem_wrdata (out, DW), o_mem_byte_en (out, DW/8), i_mem_rddata (in, DW), meaning one shared synchronous single-port memory with read latency exactly 1 cycle.

Function
REQ-008 SHALL issue at most one memory command per cycle; a requester is "requesting" when pc_rd, or ldst_rd|ldst_wr, is 1.
REQ-009 SHALL grant combinationally in the same cycle: only one requester -> that requester; both -> the one not granted most recently (register last_grant, 1 bit: 0=pc, 1=ldst).
REQ-010 SHALL update last_grant on every cycle a grant is issued; no update when nobody requests.
REQ-011 SHALL drive o_pc_waitreq = i_pc_rd & ~grant_pc, and o_ldst_waitreq = (i_ldst_rd|i_ldst_wr) & ~grant_ldst; the requester holds its command stable while waitreq is 1.
REQ-012 SHALL drive the o_mem_* command from the granted requester; pc grant -> o_mem_rd=1, o_mem_byte_en all ones; no grant -> o_mem_rd=o_mem_wr=0.
REQ-013 SHALL treat i_ldst_rd and i_ldst_wr both 1 as a read; wr ignored, o_mem_wr=0.
REQ-014 SHALL implement a read-tracking FSM with states IDLE, PC_RD, LS_RD: next state PC_RD after a pc read grant, LS_RD after an ldst read grant, IDLE otherwise (writes included), evaluated every cycle from any state.
REQ-015 SHALL assert o_pc_rdvalid=1 only in PC_RD and o_ldst_rdvalid=1 only in LS_RD, each for exactly one cycle per read, i.e. 1 cycle after grant.
REQ-016 SHALL pass i_mem_rddata to o_pc_rddata and o_ldst_rddata combinationally; data is meaningful only with the matching rdvalid.
REQ-017 SHALL support back-to-back issue: a new grant in the same cycle a previous read's rdvalid is asserted, giving sustained 1 transaction/cycle.
REQ-018 SHALL complete a write in its grant cycle with no response strobe.
REQ-019 SHALL guarantee starvation freedom: under continuous contention, grants strictly alternate pc, ldst, pc, ...

Reset
REQ-020 SHALL, while reset=0, force the FSM to IDLE, last_grant=1 (pc wins first contention), and both rdvalid outputs to 0.
REQ-021 SHALL, on reset assertion mid-read (PC_RD or LS_RD), drop the pending rdvalid; the read is never reported after reset release.
REQ-022 SHALL operate normally from the first rising clk edge after reset returns to 1; waitreq and o_mem_* stay purely combinational of inputs and last_grant.

Verification
REQ-023 SHALL cover pc-only read: i_pc_rd=1, addr=0x10, mem returns 0xDEADBEEF -> waitreq 0, o_mem_rd=1, o_mem_addr=0x10; next cycle o_pc_rdvalid=1, o_pc_rddata=0xDEADBEEF.
REQ-024 SHALL cover first contention after reset: pc rd 0x0, ldst rd 0x100 both held -> cycle0 pc granted, ldst waitreq=1; cycle1 ldst granted, o_pc_rdvalid=1; cycle2 o_ldst_rdvalid=1.
REQ-025 SHALL cover ldst write: wr=1, addr=0x20, wrdata=0x000000AB, byte_en=0001 -> o_mem_wr=1 with same values for one cycle, no rdvalid next cycle, FSM stays IDLE.
REQ-026 SHALL cover 8 cycles of continuous contention -> grants alternate exactly pc,ldst x4, each rdvalid asserted 4 times, never both in one cycle.
REQ-027 SHALL cover reset=0 asynchronously in the cycle after a pc read grant -> o_pc_rdvalid falls to 0 immediately and never pulses after reset=1.
REQ-028 SHALL cover ldst rd=wr=1 -> o_mem_rd=1, o_mem_wr=0, o_ldst_rdvalid=1 next cycle.
